reaction_game_ctrl: RTL and testbench

REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

---
 rtl/reaction_pkg.sv | 26 ++
 rtl/player_prio_enc.sv | 18 +
 rtl/reaction_game_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_reaction_game_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types for the reaction game controller: FSM states, display select codes
// and a saturating ms increment.
package reaction_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_WAIT_MIN = 3'd2,
      ST_WAIT_RND = 3'd3,
      ST_GO       = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      MUL_SHOW  = 2'b00,
      MUL_BLINK = 2'b10,
      MUL_BLANK = 2'b11
   } mul_sel_t;

   localparam logic [15:0] MS_MAX = 16'hFFFF;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == MS_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/player_prio_enc.sv
// Fixed-priority encoder for player keys: the lowest requesting index wins.
module player_prio_enc #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   output logic [2:0]   idx,
   output logic         valid
);

   always_comb begin
      idx   = 3'd0;
      valid = |req;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = 3'(i);
      end
   end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction game round sequencer and thermometer scoreboard.
// Optional early-press penalty is enabled with `define REACTION_FALSE_START_EN.
//
// state    | meaning
// IDLE     | post-reset, arms on next cycle
// ARM      | request new random value, reload pre-delay timer
// WAIT_MIN | fixed pre-delay, then latch random delay when available
// WAIT_RND | random delay countdown
// GO       | reaction window, react_ms counts up
// DONE     | result frozen until start_n pressed
module reaction_game_ctrl
   import reaction_pkg::*;
#(
   parameter int NUM_PLAYERS  = 2,
   parameter int SCORE_W      = 5,
   parameter int MIN_DELAY_MS = 3000,
   parameter int TIMEOUT_MS   = 5000
) (
   input  logic                         CLOCK50,
   input  logic                         reset,
   input  logic                         ms_tick,
   input  logic                         start_n,
   input  logic [NUM_PLAYERS-1:0]       btn_n,
   input  logic [15:0]                  rnd_value,
   input  logic                         rnd_ready,
   output logic                         rng_resume,
   output logic [1:0]                   mul_sel,
   output logic [15:0]                  react_ms,
   output logic [2:0]                   winner,
   output logic                         winner_valid,
   output logic [NUM_PLAYERS*SCORE_W-1:0] score,
   output logic                         game_over,
   output logic                         false_start
);

   localparam logic [15:0] MIN_LOAD    = 16'(MIN_DELAY_MS);
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_MS);

   state_t               state;
   mul_sel_t             mul_q;
   logic [15:0]          delay_cnt;
   logic [SCORE_W-1:0]   bar [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] press_req;
   logic [2:0]           press_idx;
   logic                 press_any;
   logic                 early_press;
   logic [15:0]          react_inc;
   logic                 timeout_hit;
   logic                 react_at_limit;

   assign press_req = ~btn_n;

   player_prio_enc #(.N(NUM_PLAYERS)) u_prio (
      .req   (press_req),
      .idx   (press_idx),
      .valid (press_any)
   );

`ifdef REACTION_FALSE_START_EN
   logic false_start_q;
   assign early_press = press_any;
   assign false_start = false_start_q;
`else
   assign early_press = 1'b0;
   assign false_start = 1'b0;
`endif

   assign react_inc      = sat_inc16(react_ms);
   assign timeout_hit    = ({16'h0, react_inc} >= TIMEOUT_LIM);
   assign react_at_limit = ({16'h0, react_ms} >= TIMEOUT_LIM);
   assign mul_sel        = mul_q;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
      assign score[g*SCORE_W +: SCORE_W] = bar[g];
   end

   always_comb begin
      game_over = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (&bar[p]) game_over = 1'b1;
      end
   end

   always_ff @(posedge CLOCK50 or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         mul_q        <= MUL_BLANK;
         delay_cnt    <= 16'd0;
         react_ms     <= 16'd0;
         winner       <= 3'd0;
         winner_valid <= 1'b0;
         rng_resume   <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) bar[p] <= '0;
`ifdef REACTION_FALSE_START_EN
         false_start_q <= 1'b0;
`endif
      end else begin
         rng_resume <= 1'b0;
         case (state)
            ST_IDLE: begin
               state      <= ST_ARM;
               rng_resume <= 1'b1;
               mul_q      <= MUL_BLINK;
            end
            ST_ARM: begin
               state     <= ST_WAIT_MIN;
               mul_q     <= MUL_BLANK;
               delay_cnt <= MIN_LOAD;
               react_ms  <= 16'd0;
            end
            ST_WAIT_MIN, ST_WAIT_RND: begin
               if (early_press) begin
                  state        <= ST_DONE;
                  mul_q        <= MUL_SHOW;
                  winner       <= press_idx;
                  winner_valid <= 1'b0;
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     if (press_idx == 3'(p)) bar[p] <= bar[p] >> 1;
                  end
`ifdef REACTION_FALSE_START_EN
                  false_start_q <= 1'b1;
`endif
               end else if (state == ST_WAIT_MIN) begin
                  // a tick on the exit cycle is dropped; the random delay starts fresh
                  if (delay_cnt == 16'd0 && rnd_ready) begin
                     state     <= ST_WAIT_RND;
                     delay_cnt <= rnd_value;
                  end else if (ms_tick && delay_cnt != 16'd0) begin
                     delay_cnt <= delay_cnt - 16'd1;
                  end
               end else begin
                  if (delay_cnt == 16'd0) begin
                     state    <= ST_GO;
                     mul_q    <= MUL_SHOW;
                     react_ms <= ms_tick ? 16'd1 : 16'd0;
                  end else if (ms_tick) begin
                     delay_cnt <= delay_cnt - 16'd1;
                  end
               end
            end
            ST_GO: begin
               if (press_any) begin
                  state        <= ST_DONE;
                  winner       <= press_idx;
                  winner_valid <= 1'b1;
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     if (press_idx == 3'(p)) bar[p] <= {bar[p][SCORE_W-2:0], 1'b1};
                  end
               end else if (react_at_limit) begin
                  state        <= ST_DONE;
                  winner_valid <= 1'b0;
               end else if (ms_tick) begin
                  react_ms <= react_inc;
                  if (timeout_hit) begin
                     state        <= ST_DONE;
                     winner_valid <= 1'b0;
                  end
               end
            end
            ST_DONE: begin
               if (!start_n) begin
                  state        <= ST_ARM;
                  rng_resume   <= 1'b1;
                  mul_q        <= MUL_BLINK;
                  winner_valid <= 1'b0;
`ifdef REACTION_FALSE_START_EN
                  false_start_q <= 1'b0;
`endif
                  if (game_over) begin
                     for (int p = 0; p < NUM_PLAYERS; p++) bar[p] <= '0;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               mul_q <= MUL_BLANK;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with four players and a short pre-delay.
module tb_reaction_game_ctrl;

   logic        CLOCK50 = 1'b0;
   logic        reset;
   logic        ms_tick;
   logic        start_n;
   logic [3:0]  btn_n;
   logic [15:0] rnd_value;
   logic        rnd_ready;
   logic        rng_resume;
   logic [1:0]  mul_sel;
   logic [15:0] react_ms;
   logic [2:0]  winner;
   logic        winner_valid;
   logic [19:0] score;
   logic        game_over;
   logic        false_start;

   int n_checks = 0;
   int n_fail   = 0;
   logic [19:0] exp_score;
   logic [4:0]  exp_bar;

   always #5 CLOCK50 = ~CLOCK50;

   reaction_game_ctrl #(
      .NUM_PLAYERS (4),
      .SCORE_W     (5),
      .MIN_DELAY_MS(30),
      .TIMEOUT_MS  (5000)
   ) dut (
      .CLOCK50     (CLOCK50),
      .reset       (reset),
      .ms_tick     (ms_tick),
      .start_n     (start_n),
      .btn_n       (btn_n),
      .rnd_value   (rnd_value),
      .rnd_ready   (rnd_ready),
      .rng_resume  (rng_resume),
      .mul_sel     (mul_sel),
      .react_ms    (react_ms),
      .winner      (winner),
      .winner_valid(winner_valid),
      .score       (score),
      .game_over   (game_over),
      .false_start (false_start)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK50);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         ms_tick = 1'b1;
         step();
         ms_tick = 1'b0;
         step();
      end
   endtask

   task automatic go_wait(input string tag, input int exp_ticks);
      int n;
      n = 0;
      while (mul_sel != 2'b00 && n < 10000) begin
         tick(1);
         n++;
      end
      check(tag, 32'(n), 32'(exp_ticks));
   endtask

   task automatic start_round();
      start_n = 1'b0;
      step();
      start_n = 1'b1;
      check("arm_rng_resume", {31'd0, rng_resume}, 32'd1);
      step();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_mul"},   {30'd0, mul_sel}, 32'h3);
      check({tag, "_rng"},   {31'd0, rng_resume}, 32'd0);
      check({tag, "_score"}, {12'd0, score}, 32'd0);
      check({tag, "_react"}, {16'd0, react_ms}, 32'd0);
      check({tag, "_win"},   {29'd0, winner}, 32'd0);
      check({tag, "_wv"},    {31'd0, winner_valid}, 32'd0);
      check({tag, "_go"},    {31'd0, game_over}, 32'd0);
      check({tag, "_fs"},    {31'd0, false_start}, 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      ms_tick   = 1'b0;
      start_n   = 1'b1;
      btn_n     = 4'hF;
      rnd_value = 16'd500;
      rnd_ready = 1'b1;
      step();
      step();
      check_reset_vals("rst");
      reset = 1'b0;
      step();
      check("idle_to_arm_rng", {31'd0, rng_resume}, 32'd1);
      check("arm_mul", {30'd0, mul_sel}, 32'h2);
      step();
      check("wmin_mul", {30'd0, mul_sel}, 32'h3);

      // round 1: 30 + 500 ms delay, player 1 reacts after 230 ms
      go_wait("r1_delay", 530);
      check("r1_go_react0", {16'd0, react_ms}, 32'd0);
      tick(230);
      btn_n = 4'b1101;
      step();
      btn_n = 4'hF;
      check("r1_winner", {29'd0, winner}, 32'd1);
      check("r1_wv", {31'd0, winner_valid}, 32'd1);
      check("r1_react", {16'd0, react_ms}, 32'd230);
      check("r1_score", {12'd0, score}, 32'h00020);
      tick(3);
      check("r1_frozen", {16'd0, react_ms}, 32'd230);

      // round 2: random value late, simultaneous press of players 0 and 2
      rnd_value = 16'd50;
      rnd_ready = 1'b0;
      start_round();
      tick(33);
      check("r2_wait_rdy", {30'd0, mul_sel}, 32'h3);
      rnd_ready = 1'b1;
      step();
      go_wait("r2_delay", 50);
      tick(7);
      btn_n = 4'b1010;
      step();
      btn_n = 4'hF;
      check("r2_winner", {29'd0, winner}, 32'd0);
      check("r2_react", {16'd0, react_ms}, 32'd7);
      check("r2_score", {12'd0, score}, 32'h00021);

      // round 3: player 0 again
      start_round();
      go_wait("r3_delay", 80);
      tick(3);
      btn_n = 4'b1110;
      step();
      btn_n = 4'hF;
      check("r3_score", {12'd0, score}, 32'h00023);

`ifdef REACTION_FALSE_START_EN
      // round 4: player 0 jumps the gun during the pre-delay
      start_round();
      tick(10);
      btn_n = 4'b1110;
      step();
      btn_n = 4'hF;
      check("fs_flag", {31'd0, false_start}, 32'd1);
      check("fs_winner", {29'd0, winner}, 32'd0);
      check("fs_wv", {31'd0, winner_valid}, 32'd0);
      check("fs_score", {12'd0, score}, 32'h00021);
      exp_score = 20'h00021;
      exp_bar   = 5'b00001;
`else
      // round 4: early press is ignored, key held into GO wins at once
      start_round();
      tick(5);
      btn_n = 4'b0111;
      step();
      step();
      check("early_ignored", {30'd0, mul_sel}, 32'h3);
      check("fs_tied", {31'd0, false_start}, 32'd0);
      go_wait("r4_delay", 75);
      step();
      btn_n = 4'hF;
      check("held_winner", {29'd0, winner}, 32'd3);
      check("held_wv", {31'd0, winner_valid}, 32'd1);
      check("held_react", {16'd0, react_ms}, 32'd0);
      check("held_score", {12'd0, score}, 32'h08023);
      exp_score = 20'h08023;
      exp_bar   = 5'b00011;
`endif

      // round 5: nobody presses, window closes at 5000 ms
      start_round();
      check("r5_fs_clear", {31'd0, false_start}, 32'd0);
      go_wait("r5_delay", 80);
      tick(4999);
      check("to_4999", {16'd0, react_ms}, 32'd4999);
      tick(1);
      check("to_5000", {16'd0, react_ms}, 32'd5000);
      tick(3);
      btn_n = 4'b1101;
      step();
      btn_n = 4'hF;
      check("to_frozen", {16'd0, react_ms}, 32'd5000);
      check("to_wv", {31'd0, winner_valid}, 32'd0);
      check("to_score", {12'd0, score}, {12'd0, exp_score});
      check("to_gameover0", {31'd0, game_over}, 32'd0);

      // player 0 wins until the bar fills
      for (int r = 0; r < 5 && exp_bar != 5'b11111; r++) begin
         start_round();
         go_wait("fill_delay", 80);
         tick(2);
         btn_n = 4'b1110;
         step();
         btn_n = 4'hF;
         exp_bar = {exp_bar[3:0], 1'b1};
         check("fill_bar", {27'd0, score[4:0]}, {27'd0, exp_bar});
      end
      check("full_bar", {27'd0, score[4:0]}, 32'h1F);
      check("game_over", {31'd0, game_over}, 32'd1);
      start_round();
      check("go_clear_score", {12'd0, score}, 32'd0);
      check("go_clear_flag", {31'd0, game_over}, 32'd0);

      // reset in the middle of the random delay
      tick(40);
      check("mid_wrnd_mul", {30'd0, mul_sel}, 32'h3);
      reset = 1'b1;
      step();
      check_reset_vals("midrst");
      reset = 1'b0;
      step();
      check("midrst_idle_arm", {31'd0, rng_resume}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
